// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM-stage
// port and a debug/loader master. The CPU wins by default. The debug master
// gains priority after MAX_WAIT denied cycles and may lock the memory for
// bursts of up to LOCK_MAX grants.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [3:0]        dbg_be,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {CPU_PRI, DBG_PRI, DBG_LOCK} state_e;
  typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_DBG} owner_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  // The grant that enters DBG_LOCK is the first of the burst; lock_cnt is
  // cleared on entry and only counts the remaining LOCK_MAX-1 grants.
  localparam logic [7:0] LOCK_LAST  = 8'(LOCK_MAX - 1);
  localparam bit         LOCK_EN    = (LOCK_MAX > 1);

  state_e      state_q, state_d;
  owner_e      rd_owner_q, rd_owner_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        cpu_grant, dbg_grant;

  // Grant decision from current state and requests; nothing granted in reset.
  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (rst) begin
      case (state_q)
        CPU_PRI: begin
          cpu_grant = cpu_req;
          dbg_grant = dbg_req & ~cpu_req;
        end
        DBG_PRI: begin
          dbg_grant = dbg_req;
          cpu_grant = cpu_req & ~dbg_req;
        end
        DBG_LOCK: dbg_grant = dbg_req;
        default: ;
      endcase
    end
  end

  // Route the granted master onto the memory port; idle port drives zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_be    = cpu_be;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_grant) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_be    = dbg_be;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign cpu_stall  = rst & cpu_req & ~cpu_grant;
  assign dbg_gnt    = dbg_grant;
  assign cpu_rvalid = (rd_owner_q == RD_CPU);
  assign dbg_rvalid = (rd_owner_q == RD_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

  // Next state: starvation counter, lock burst counter and read owner.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    wait_cnt_d = '0;
    if (dbg_req && !dbg_grant)
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    rd_owner_d = RD_NONE;
    if (cpu_grant && !cpu_we)      rd_owner_d = RD_CPU;
    else if (dbg_grant && !dbg_we) rd_owner_d = RD_DBG;
    case (state_q)
      CPU_PRI: begin
        if (dbg_grant && dbg_lock && LOCK_EN) begin
          state_d    = DBG_LOCK;
          lock_cnt_d = '0;
        end else if (wait_cnt_d >= MAX_WAIT_C) begin
          state_d = DBG_PRI;
        end
      end
      DBG_PRI: begin
        if (dbg_grant && dbg_lock && LOCK_EN) begin
          state_d    = DBG_LOCK;
          lock_cnt_d = '0;
        end else if (dbg_grant || !dbg_req) begin
          state_d = CPU_PRI;
        end
      end
      DBG_LOCK: begin
        if (dbg_grant) lock_cnt_d = lock_cnt_q + 8'd1;
        if (!dbg_req || !dbg_lock || lock_cnt_d >= LOCK_LAST) begin
          state_d    = CPU_PRI;
          lock_cnt_d = '0;
          wait_cnt_d = '0;
        end
      end
      default: state_d = CPU_PRI;
    endcase
  end

  // State registers; reset drops any lock and any outstanding read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CPU_PRI;
      wait_cnt_q <= '0;
      lock_cnt_q <= '0;
      rd_owner_q <= RD_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// against a priority/burst/read-queue model and a shadow memory.
module tb_dmem_arbiter;
  localparam int ADDR_W = 10, MAX_WAIT = 4, LOCK_MAX = 8;

  logic clk, rst;
  logic cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [3:0] cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [3:0] dbg_be;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic mem_en, mem_we;
  logic [3:0] mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int total, bad;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory attached to the DUT port; cleared on every reset edge.
  logic [31:0] phys_mem [0:1023];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) phys_mem[i] <= '0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) phys_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= phys_mem[mem_addr];
      end
    end
  end

  // Reference model: who has priority, how long debug has starved, how many
  // grants the current locked burst has used, and the read awaiting return.
  int          m_streak, m_burst, m_pend;  // m_pend: 0 none, 1 cpu, 2 dbg
  bit          m_dbg_first;
  logic [31:0] m_pend_data;
  logic [31:0] ref_mem [0:1023];
  logic        e_cg, e_dg, e_stall, e_en, e_we, e_crv, e_drv;
  logic [3:0]  e_be;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0] e_wdata, e_crd, e_drd;

  task automatic model_reset();
    m_streak = 0; m_burst = 0; m_pend = 0; m_dbg_first = 0; m_pend_data = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
  endtask

  task automatic model_eval();
    e_cg = 0; e_dg = 0; e_stall = 0; e_en = 0; e_we = 0; e_be = '0;
    e_addr = '0; e_wdata = '0; e_crv = 0; e_drv = 0; e_crd = '0; e_drd = '0;
    if (rst) begin
      if (m_burst > 0) e_dg = dbg_req;
      else if (m_dbg_first) begin e_dg = dbg_req; e_cg = cpu_req && !dbg_req; end
      else begin e_cg = cpu_req; e_dg = dbg_req && !cpu_req; end
      e_stall = cpu_req && !e_cg;
      if (e_cg) begin
        e_en = 1; e_we = cpu_we; e_be = cpu_be; e_addr = cpu_addr; e_wdata = cpu_wdata;
      end else if (e_dg) begin
        e_en = 1; e_we = dbg_we; e_be = dbg_be; e_addr = dbg_addr; e_wdata = dbg_wdata;
      end
      e_crv = (m_pend == 1); e_crd = e_crv ? m_pend_data : '0;
      e_drv = (m_pend == 2); e_drd = e_drv ? m_pend_data : '0;
    end
  endtask

  task automatic model_commit();
    model_eval();
    if (!rst) begin model_reset(); return; end
    m_pend = 0;
    if (e_en) begin
      if (e_we) begin
        for (int b = 0; b < 4; b++)
          if (e_be[b]) ref_mem[e_addr][8*b +: 8] = e_wdata[8*b +: 8];
      end else begin
        m_pend = e_cg ? 1 : 2;
        m_pend_data = ref_mem[e_addr];
      end
    end
    if (dbg_req && !e_dg) m_streak = (m_streak < 255) ? m_streak + 1 : 255;
    else m_streak = 0;
    if (m_burst > 0) begin
      if (e_dg) m_burst++;
      if (!dbg_req || !dbg_lock || m_burst >= LOCK_MAX) begin m_burst = 0; m_streak = 0; end
    end else if (e_dg && dbg_lock && LOCK_MAX > 1) begin
      m_burst = 1; m_dbg_first = 0;
    end else if (m_dbg_first) begin
      if (e_dg || !dbg_req) m_dbg_first = 0;
    end else if (m_streak >= MAX_WAIT) begin
      m_dbg_first = 1;
    end
  endtask

  function automatic logic [115:0] obs_vec();
    return {cpu_stall, dbg_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata,
            cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata};
  endfunction
  function automatic logic [115:0] exp_vec();
    return {e_stall, e_dg, e_en, e_we, e_be, e_addr, e_wdata, e_crv, e_crd, e_drv, e_drd};
  endfunction

  task automatic step();
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [3:0] be,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = a; cpu_wdata = d;
  endtask
  task automatic set_dbg(input logic req, input logic we, input logic lock, input logic [3:0] be,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
    dbg_req = req; dbg_we = we; dbg_lock = lock; dbg_be = be; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    set_cpu(1, 1, 4'hF, 10'd3, 32'h11112222);
    set_dbg(1, 0, 1, 4'hF, 10'd4, 32'h0);
    @(negedge clk); model_eval();
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec()); end
    total++;
    if (obs_vec() !== 116'd0) begin bad++; $display("FAIL reset_all_zero got=%h exp=0", obs_vec()); end
    @(posedge clk); model_commit(); #1;
    rst = 1;
    set_cpu(0, 0, 4'h0, '0, '0); set_dbg(0, 0, 0, 4'h0, '0, '0);
    @(negedge clk); model_eval();
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec()); end
    step();
  endtask

  task automatic test_cpu_only();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) set_cpu(1, 1, 4'hF, 10'd0, 32'h12345001);
      else if (c == 1) set_cpu(1, 0, 4'hF, 10'd0, 32'h0);
      else set_cpu(0, 0, 4'h0, '0, '0);
      @(negedge clk); model_eval();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL cpu_only c%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      total++;
      if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_only_stall c%0d got=%b exp=0", c, cpu_stall); end
      if (c == 2) begin
        total++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h12345001}) begin
          bad++; $display("FAIL cpu_only_load got=%b/%h exp=1/12345001", cpu_rvalid, cpu_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_dbg_only();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) set_dbg(1, 1, 0, 4'hF, 10'd5, 32'hDEADBEEF);
      else if (c == 1) set_dbg(1, 0, 0, 4'hF, 10'd5, 32'h0);
      else set_dbg(0, 0, 0, 4'h0, '0, '0);
      @(negedge clk); model_eval();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL dbg_only c%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      total++;
      if (dbg_gnt !== (c < 2)) begin bad++; $display("FAIL dbg_only_gnt c%0d got=%b exp=%b", c, dbg_gnt, c < 2); end
      if (c == 2) begin
        total++;
        if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'hDEADBEEF}) begin
          bad++; $display("FAIL dbg_only_read got=%b/%h exp=1/deadbeef", dbg_rvalid, dbg_rdata);
        end
      end
      step();
    end
  endtask

  // Both masters hold requests: four CPU grants, then one debug grant, repeating.
  task automatic test_starvation();
    logic exp_d;
    set_cpu(1, 0, 4'hF, 10'd7, '0);
    set_dbg(1, 0, 0, 4'hF, 10'd9, '0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); model_eval();
      exp_d = ((c % 5) == 4);
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL starve c%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      total++;
      if ({dbg_gnt, cpu_stall} !== {exp_d, exp_d}) begin
        bad++; $display("FAIL starve_pattern c%0d got=%b%b exp=%b%b", c, dbg_gnt, cpu_stall, exp_d, exp_d);
      end
      step();
    end
    set_cpu(0, 0, 4'h0, '0, '0); set_dbg(0, 0, 0, 4'h0, '0, '0);
    @(negedge clk); model_eval();
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL starve_drain got=%h exp=%h", obs_vec(), exp_vec()); end
    step();
  endtask

  // Debug writes with dbg_lock while the CPU keeps requesting.
  task automatic test_lock_burst();
    bit gq[$], sq[$];
    int g, f, r;
    bit stall_ok;
    g = 0;
    set_cpu(1, 1, 4'hF, 10'd20, 32'hC0DE0000);
    set_dbg(1, 1, 1, 4'hF, 10'd100, 32'hB0000000);
    for (int c = 0; c < 60 && g < 12; c++) begin
      @(negedge clk); model_eval();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL lock c%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      gq.push_back(dbg_gnt); sq.push_back(cpu_stall);
      if (dbg_gnt) g++;
      step();
      if (g >= 12) set_dbg(0, 0, 0, 4'h0, '0, '0);
      else begin dbg_addr = 10'(100 + g); dbg_wdata = 32'hB0000000 + 32'(g); end
    end
    total++;
    if (g != 12) begin bad++; $display("FAIL lock_timeout got=%0d exp=12", g); end
    f = 0;
    while (f < gq.size() && !gq[f]) f++;
    r = 0;
    stall_ok = 1;
    while (f + r < gq.size() && gq[f + r]) begin
      if (!sq[f + r]) stall_ok = 0;
      r++;
    end
    total++;
    if (r != LOCK_MAX || !stall_ok) begin
      bad++; $display("FAIL lock_run got=%0d/%0d exp=%0d/1", r, stall_ok, LOCK_MAX);
    end
    total++;
    if (f + r >= gq.size() || gq[f + r] || sq[f + r]) begin
      bad++; $display("FAIL lock_release_cpu idx=%0d exp cpu granted", f + r);
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 2) set_cpu(0, 0, 4'h0, '0, '0);
      @(negedge clk); model_eval();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL lock_drain c%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      step();
    end
  endtask

  // CPU read of 0 then debug read of 5 on the next cycle.
  task automatic test_mixed_reads();
    logic [1:0]  exp_rv [4];
    logic [31:0] exp_cd [4];
    logic [31:0] exp_dd [4];
    exp_rv = '{2'b00, 2'b10, 2'b01, 2'b00};
    exp_cd = '{32'h0, 32'h12345001, 32'h0, 32'h0};
    exp_dd = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin set_cpu(1, 0, 4'hF, 10'd0, '0); set_dbg(0, 0, 0, 4'h0, '0, '0); end
      else if (c == 1) begin set_cpu(0, 0, 4'h0, '0, '0); set_dbg(1, 0, 0, 4'hF, 10'd5, '0); end
      else begin set_cpu(0, 0, 4'h0, '0, '0); set_dbg(0, 0, 0, 4'h0, '0, '0); end
      @(negedge clk); model_eval();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL mixed c%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      total++;
      if ({cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata} !== {exp_rv[c], exp_cd[c], exp_dd[c]}) begin
        bad++; $display("FAIL mixed_order c%0d got=%b%b/%h/%h exp=%b/%h/%h", c, cpu_rvalid, dbg_rvalid,
                        cpu_rdata, dbg_rdata, exp_rv[c], exp_cd[c], exp_dd[c]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_lock();
    set_cpu(0, 0, 4'h0, '0, '0);
    set_dbg(1, 0, 1, 4'hF, 10'd5, '0);
    @(negedge clk); model_eval();
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rml_enter got=%h exp=%h", obs_vec(), exp_vec()); end
    step();
    set_cpu(1, 0, 4'hF, 10'd0, '0);
    set_dbg(1, 0, 1, 4'hF, 10'd6, '0);
    @(negedge clk); model_eval();
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rml_locked got=%h exp=%h", obs_vec(), exp_vec()); end
    step();
    #1 rst = 0;
    #1;
    total++;
    if (obs_vec() !== 116'd0) begin bad++; $display("FAIL rml_outputs_zero got=%h exp=0", obs_vec()); end
    step();
    rst = 1;
    @(negedge clk); model_eval();
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rml_after got=%h exp=%h", obs_vec(), exp_vec()); end
    total++;
    if ({cpu_stall, dbg_gnt, mem_en, cpu_rvalid, dbg_rvalid} !== 5'b00100) begin
      bad++; $display("FAIL rml_cpu_first got=%b%b%b%b%b exp=00100", cpu_stall, dbg_gnt, mem_en, cpu_rvalid, dbg_rvalid);
    end
    step();
    set_cpu(0, 0, 4'h0, '0, '0); set_dbg(0, 0, 0, 4'h0, '0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); model_eval();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rml_drain c%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      step();
    end
  endtask

  // Random traffic; a denied master holds its request unchanged.
  task automatic test_random();
    bit hold_c, hold_d;
    hold_c = 0; hold_d = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_c)
        set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 4'($urandom()),
                10'($urandom_range(0, 15)), $urandom());
      if (!hold_d)
        set_dbg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                4'($urandom()), 10'($urandom_range(0, 15)), $urandom());
      @(negedge clk); model_eval();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL random c%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      hold_c = e_stall;
      hold_d = dbg_req && !e_dg;
      step();
    end
    set_cpu(0, 0, 4'h0, '0, '0); set_dbg(0, 0, 0, 4'h0, '0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); model_eval();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL random_drain c%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      step();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_cpu_only();
    test_dbg_only();
    test_starvation();
    test_lock_burst();
    test_mixed_reads();
    test_reset_mid_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipelined CPU's MEM-stage load/store port and a debug/loader master (memory preload, result readback).
- CPU has default priority. The debug master is protected against starvation by a wait counter and may lock the memory for short bursts.
- The CPU pipeline is frozen via cpu_stall whenever its access is not granted.
- The block sits between the MEM stage / debug port and the data memory instance.

Parameters:
- ADDR_W, 10, word-address width of the data memory.
- MAX_WAIT, 4, consecutive denied debug cycles before debug gets priority (1..255).
- LOCK_MAX, 8, maximum consecutive locked debug grants before forced release (1..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until not stalled.
- cpu_we  in  1  CPU write enable.
- cpu_be  in  4  CPU byte enables.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  32  CPU store data.
- cpu_stall  out  1  cpu_req high and not granted this cycle.
- cpu_rvalid  out  1  CPU read data valid (one cycle after a granted read).
- cpu_rdata  out  32  CPU read data.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  debug write enable.
- dbg_be  in  4  debug byte enables.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  32  debug store data.
- dbg_lock  in  1  request to retain ownership after the current grant.
- dbg_gnt  out  1  debug access accepted this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  32  debug read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_we low.

Behaviour:
- Reset (rst low, asynchronous): state CPU_PRI, wait_cnt=0, lock_cnt=0, rd_owner=NONE.
  - While reset is asserted, every output is 0, including cpu_stall and mem_en, regardless of requests.
  - A reset in the middle of a lock or pending read discards it; no rvalid follows.
- Grant decision is combinational from the current state and requests. At most one grant per cycle.
  - CPU_PRI: CPU granted if cpu_req; otherwise debug granted if dbg_req.
  - DBG_PRI: debug granted if dbg_req; otherwise CPU granted if cpu_req.
  - DBG_LOCK: debug only, if dbg_req. The CPU is stalled even when debug is idle.
- Memory outputs:
  - mem_* carries the granted master's we/be/addr/wdata, with mem_en=1.
  - With no grant: mem_en=0 and mem_we=0; addr, wdata and be are 0.
- Stall and grant outputs: cpu_stall = cpu_req & ~cpu_grant; dbg_gnt = debug grant.
- Read return:
  - A granted read registers rd_owner. Next cycle the owner's rvalid=1 and its rdata=mem_rdata.
  - The other master's rdata=0. Writes produce no rvalid.
  - Back-to-back reads from alternating owners return in issue order.
- wait_cnt:
  - Increments (saturating) each cycle dbg_req=1 and debug is not granted.
  - Clears on any debug grant or when dbg_req=0.
- State transitions (next edge):
  - CPU_PRI -> DBG_PRI when wait_cnt reaches MAX_WAIT (counting the current denied cycle).
  - DBG_PRI -> DBG_LOCK on a debug grant with dbg_lock=1.
  - DBG_PRI -> CPU_PRI on a debug grant with dbg_lock=0, or when dbg_req drops.
  - CPU_PRI -> DBG_LOCK on a debug grant with dbg_lock=1.
  - DBG_LOCK: lock_cnt increments per debug grant.
    - Exits to CPU_PRI when dbg_lock=0, dbg_req=0, or lock_cnt reaches LOCK_MAX.
    - A forced exit clears wait_cnt and lock_cnt.
    - The CPU then wins the next conflict.
  - lock_cnt clears on every entry to DBG_LOCK.
- Simultaneous requests in the same cycle are resolved strictly by the state rules above; no request is lost, and the denied master simply holds its request.

Test Plan:
- CPU-only traffic: SW 0x12345001 to address 0, then LW address 0. Required: cpu_stall never asserts; cpu_rvalid asserts one cycle after the LW grant with cpu_rdata=0x12345001.
- Debug-only traffic: write 0xDEADBEEF to address 5, then read it back. Required: dbg_gnt asserts in the request cycle; dbg_rvalid asserts the next cycle with dbg_rdata=0xDEADBEEF.
- Starvation, MAX_WAIT=4: cpu_req and dbg_req held high continuously. Required: CPU is granted 4 cycles, then debug is granted on the 5th with cpu_stall=1 for that cycle; the pattern repeats.
- Locked burst, LOCK_MAX=8: dbg_lock=1 for 12 requests while cpu_req is held high. Required: 8 consecutive debug grants, then the CPU is granted; cpu_stall=1 throughout the burst.
- Mixed reads, CPU read then debug read on alternating cycles (addresses 0 and 5). Required: cpu_rvalid and dbg_rvalid each fire once, in issue order, with the correct data, and never both in the same cycle.
- Reset mid-lock: assert rst low during DBG_LOCK with a read outstanding. Required: all outputs 0 immediately, no rvalid after release, and the first access after release goes to the CPU.
